fifo_bram_prefetch: RTL and testbench

Memory-backed FIFO stage that sits directly upstream of the register cache FIFO in the buffered FIFO chain. It stores bulk data in an inferred block RAM with multi-cycle read latency. It prefetches words into the downstream cache under a credit scheme, so in-flight reads can never overflow the cache. Together with the cache it forms a deep, low-latency Avalon-ST FIFO.

---
 rtl/fifo_bram_prefetch.sv | 175 +++++++++++++++++
 tb/tb_fifo_bram_prefetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bram_prefetch.sv
// -----------------------------------------------------------------------------
// fifo_bram_prefetch
//
// Memory-backed FIFO stage placed directly upstream of a register cache FIFO.
// Bulk words live in an inferred block RAM with RD_LATENCY cycles of read
// latency. Words are prefetched into the downstream cache under a credit
// scheme. The credit counter starts at the cache depth (CREDITS), so the
// number of in-flight plus cached words can never exceed the cache capacity.
//
// Parameters:
//   DATA_WIDTH  word width
//   MEM_DEPTH   RAM depth in words (power of two, >= 2)
//   RD_LATENCY  cycles from read issue to valid_o (>= 1)
//   CREDITS     downstream cache depth / initial credit count (>= 1)
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-high reset
//   data_i    write data
//   valid_i   write data valid
//   ready_o   can accept a write (not full)
//   data_o    prefetched word, meaningful only while valid_o = 1
//   valid_o   one-cycle push strobe into the downstream cache
//   credit_i  one pulse per word popped from the downstream cache
//   err_o     sticky credit-overflow flag, cleared only by reset
//   level_o   stored word count (only with FIFO_BRAM_PREFETCH_LEVEL_EN)
//
// Optional feature macro: FIFO_BRAM_PREFETCH_LEVEL_EN adds level_o.
// -----------------------------------------------------------------------------
module fifo_bram_prefetch #(
  parameter int DATA_WIDTH = 11,
  parameter int MEM_DEPTH  = 16,
  parameter int RD_LATENCY = 2,
  parameter int CREDITS    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      valid_o,
  input  logic                      credit_i,
`ifdef FIFO_BRAM_PREFETCH_LEVEL_EN
  output logic [$clog2(MEM_DEPTH):0] level_o,
`endif
  output logic                      err_o
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CREDITS + 1);

  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CRD_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CRD_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CRD_MAX  = CW'(CREDITS);

  // Storage, pointers and credit state
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_credits;
  logic                  r_err;

  // Read pipeline: valid shift register and matching data stages
  logic [RD_LATENCY-1:0] r_vld;
  logic [DATA_WIDTH-1:0] r_dpipe [RD_LATENCY];

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_en;
  logic                  w_issue;
  logic [CW-1:0]         w_credits_nxt;
  logic                  w_err_set;

  // Wrap bit distinguishes full (same slot, different lap) from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Both qualifiers come from registered state, so a read and a write can
  // never target the same slot in one cycle.
  assign w_wr_en = valid_i && !w_full;
  assign w_issue = !w_empty && (r_credits != CRD_ZERO);

  assign ready_o = !w_full;
  assign valid_o = r_vld[RD_LATENCY-1];
  assign data_o  = r_dpipe[RD_LATENCY-1];
  assign err_o   = r_err;

`ifdef FIFO_BRAM_PREFETCH_LEVEL_EN
  // In-flight words are already excluded because rd_ptr advances at issue.
  assign level_o = r_wr_ptr - r_rd_ptr;
`endif

  // Credit update and overflow detection
  always_comb begin
    w_credits_nxt = r_credits;
    w_err_set     = 1'b0;
    case ({w_issue, credit_i})
      2'b10: begin
        w_credits_nxt = r_credits - CRD_ONE;
      end
      2'b01: begin
        if (r_credits == CRD_MAX) begin
          // Returned credit with nothing outstanding: hold and flag.
          w_credits_nxt = r_credits;
          w_err_set     = 1'b1;
        end else begin
          w_credits_nxt = r_credits + CRD_ONE;
        end
      end
      default: begin
        // Idle, or issue and return cancel out.
        w_credits_nxt = r_credits;
      end
    endcase
  end

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end else begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_mem[r_wr_ptr[AW-1:0]];
    end
  end

  // Pointer, credit and error state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr  <= {PW{1'b0}};
      r_rd_ptr  <= {PW{1'b0}};
      r_credits <= CRD_MAX;
      r_err     <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_credits <= w_credits_nxt;
      r_err     <= r_err | w_err_set;
    end
  end

  // Read pipeline: stage 0 is the RAM read register, later stages model
  // the remaining RAM latency; reset flushes every in-flight word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= {RD_LATENCY{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_dpipe[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      r_vld[0] <= w_issue;
      if (w_issue) begin
        r_dpipe[0] <= r_mem[r_rd_ptr[AW-1:0]];
      end else begin
        r_dpipe[0] <= r_dpipe[0];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_dpipe[i] <= r_dpipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fifo_bram_prefetch.sv
// -----------------------------------------------------------------------------
// tb_fifo_bram_prefetch
//
// Directed bench for fifo_bram_prefetch with default parameters
// (DATA_WIDTH 11, MEM_DEPTH 16, RD_LATENCY 2, CREDITS 4). Inputs are driven
// on the falling edge and outputs are sampled on the falling edge. A monitor
// records every valid_o word together with the rising-edge count at which
// it appeared.
// -----------------------------------------------------------------------------
module tb_fifo_bram_prefetch;

  localparam int DW = 11;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          credit_i;
  logic          err_o;
`ifdef FIFO_BRAM_PREFETCH_LEVEL_EN
  logic [4:0]    level_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_acc = 0;

  logic [DW-1:0] q_data [$];
  int            q_cyc  [$];

  fifo_bram_prefetch #(
    .DATA_WIDTH(11), .MEM_DEPTH(16), .RD_LATENCY(2), .CREDITS(4)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .credit_i(credit_i),
`ifdef FIFO_BRAM_PREFETCH_LEVEL_EN
    .level_o (level_o),
`endif
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Rising-edge counter used to timestamp output words
  always @(posedge clk_i) cyc <= cyc + 1;

  // Output monitor
  always @(negedge clk_i) begin
    if (valid_o) begin
      q_data.push_back(data_o);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qd(input int i);
    if (i < q_data.size()) return 32'(q_data[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] qc(input int i);
    if (i < q_cyc.size()) return 32'(q_cyc[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [DW-1:0] pat(input int j);
    return DW'((j * 37 + 5) & 32'h7FF);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0; credit_i = 1'b0; data_i = '0;
    idle(2);
    rst_i = 1'b0;
    idle(1);
    q_data.delete();
    q_cyc.delete();
  endtask

  // Present one word and hold it until accepted; t_acc = accepting edge count
  task automatic push(input logic [DW-1:0] d);
    int waited = 0;
    data_i  = d;
    valid_i = 1'b1;
    while (!ready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (!ready_o) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    t_acc   = cyc;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int t_first;
    int m;
    int j;
    logic acc;
    logic [DW-1:0] exp_q [$];

    // Reset state
    rst_i = 1'b1; valid_i = 1'b0; credit_i = 1'b0; data_i = '0;
    idle(2);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data",  32'(data_o),  32'd0);
    chk("rst_err",   32'(err_o),   32'd0);
    rst_i = 1'b0;
    idle(1);

    // Three words: order and first-word latency (accept edge + 2 edges)
    push(11'h001); t_first = t_acc;
    push(11'h002);
    push(11'h003);
    idle(8);
    chk("t1_count", 32'(q_data.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t1_data", qd(i), 32'(i + 1));
    chk("t1_lat_first", qc(0), 32'(t_first + 2));
    chk("t1_lat_third", qc(2), 32'(t_first + 4));

    // Credit starvation: only 4 of 8 words leave, then one per credit
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(16 + i));
    idle(10);
    chk("t2_stall_count", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_data", qd(i), 32'(16 + i));
    for (int k = 0; k < 2; k++) begin
      credit_i = 1'b1;
      @(negedge clk_i);
      m = cyc;
      credit_i = 1'b0;
      idle(5);
      chk("t2_credit_count", 32'(q_data.size()), 32'(5 + k));
      chk("t2_credit_data",  qd(4 + k), 32'(20 + k));
      chk("t2_credit_lat",   qc(4 + k), 32'(m + 2));
    end

`ifdef FIFO_BRAM_PREFETCH_LEVEL_EN
    // Level: 5 stored, 4 issued on initial credits
    do_reset();
    for (int i = 0; i < 5; i++) push(DW'(i));
    idle(8);
    chk("lvl_settle", 32'(level_o), 32'd1);
`endif

    // Full: drain credits, then fill 16 and hold a 17th
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      push(DW'(256 + i));
      exp_q.push_back(DW'(256 + i));
    end
    idle(6);
    for (int i = 0; i < 16; i++) begin
      push(DW'(512 + i));
      exp_q.push_back(DW'(512 + i));
    end
    chk("t3_full", 32'(ready_o), 32'd0);
    data_i = 11'h210; valid_i = 1'b1;
    exp_q.push_back(11'h210);
    idle(3);
    chk("t3_hold", 32'(ready_o), 32'd0);
    credit_i = 1'b1;
    @(negedge clk_i);
    credit_i = 1'b0;
    chk("t3_still_full", 32'(ready_o), 32'd0);
    @(negedge clk_i);
    chk("t3_ready_rise", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("t3_refull", 32'(ready_o), 32'd0);
    repeat (20) begin
      credit_i = 1'b1;
      @(negedge clk_i);
    end
    credit_i = 1'b0;
    idle(6);
    chk("t3_count", 32'(q_data.size()), 32'd21);
    for (int i = 0; i < 21; i++) chk("t3_order", qd(i), 32'(exp_q[i]));
    chk("t3_no_err", 32'(err_o), 32'd0);

    // Wrap-around: 40 words, cache returns one credit per pushed word
    do_reset();
    j = 0;
    for (int c = 0; c < 100; c++) begin
      credit_i = valid_o;
      if (j < 40) begin
        data_i = pat(j); valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      acc = valid_i && ready_o;
      @(negedge clk_i);
      if (acc) j++;
    end
    credit_i = 1'b0; valid_i = 1'b0;
    chk("t4_accepted", 32'(j), 32'd40);
    chk("t4_count", 32'(q_data.size()), 32'd40);
    for (int i = 0; i < 40; i++) chk("t4_order", qd(i), 32'(pat(i)));
    chk("t4_no_err", 32'(err_o), 32'd0);

    // Credit overflow while idle with all credits home
    credit_i = 1'b1;
    @(negedge clk_i);
    credit_i = 1'b0;
    chk("t5_err_set", 32'(err_o), 32'd1);
    idle(2);
    chk("t5_err_sticky", 32'(err_o), 32'd1);
    q_data.delete(); q_cyc.delete();
    for (int i = 0; i < 5; i++) push(DW'(768 + i));
    idle(8);
    chk("t5_credits_held", 32'(q_data.size()), 32'd4);

    // Async reset with a word in flight
    credit_i = 1'b1;
    @(negedge clk_i);
    credit_i = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(valid_o), 32'd0);
    chk("t5_rst_err",   32'(err_o),   32'd0);
    chk("t5_rst_ready", 32'(ready_o), 32'd1);
    chk("t5_rst_data",  32'(data_o),  32'd0);
    idle(2);
    rst_i = 1'b0;
    idle(6);
    chk("t5_flushed", 32'(q_data.size()), 32'd4);
    chk("t5_empty_after", 32'(valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
